// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bus: stall requests and exception info in, stall/flush/redirect out.
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 6,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16
);
  logic [STAGES-1:0] stall_req_i;
  logic [XLEN-1:0]   excepttype_i;
  logic [XLEN-1:0]   cp0_epc_i;
  logic [STAGES-1:0] stall_o;
  logic              flush_o;
  logic              new_pc_valid_o;
  logic [XLEN-1:0]   new_pc_o;
  logic              busy_o;
  logic              stall_timeout_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  redirect_cnt_o;

  // Pipeline side: raises requests, consumes control.
  modport master (
    output stall_req_i, excepttype_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_valid_o, new_pc_o, busy_o,
           stall_timeout_o, stall_cycles_o, redirect_cnt_o
  );

  // Controller side.
  modport slave (
    input  stall_req_i, excepttype_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_valid_o, new_pc_o, busy_o,
           stall_timeout_o, stall_cycles_o, redirect_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prefix stall vector, exception redirect FSM with
// multi-cycle flush, sticky stall watchdog and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int              STAGES       = 6,
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] INT_VEC      = 32'h00000020,
  parameter logic [XLEN-1:0] EXC_VEC      = 32'h00000040,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              WDOG_LIMIT   = 1024,
  parameter int              CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int WD_W = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t            r_state, w_next;
  logic [FC_W-1:0]   r_fcnt;
  logic [XLEN-1:0]   r_new_pc;
  logic [WD_W-1:0]   r_wdog;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt, r_redir_cnt;

  logic [STAGES-1:0] w_stall_raw, w_stall;
  logic              w_stall_any, w_exc, w_accept;
  logic [XLEN-1:0]   w_target;
  logic              w_flush, w_busy, w_pcv;

  assign w_exc    = |bus.excepttype_i;
  assign w_accept = (r_state == S_RUN) && w_exc;

  // Stage i holds whenever any stage at or above i requests a stall, so a
  // stalled stage also freezes everything upstream of it.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_pref
    assign w_stall_raw[gi] = |bus.stall_req_i[STAGES-1:gi];
  end

  // Exceptions and flushes override stalls: the pipeline is being cleared.
  assign w_stall     = (rst || w_exc || r_state == S_FLUSH) ? '0 : w_stall_raw;
  assign w_stall_any = |w_stall;

  // Redirect target lookup; unknown nonzero codes go to the exception vector.
  always_comb begin
    w_target = EXC_VEC;
    if (bus.excepttype_i == XLEN'(32'h01))      w_target = INT_VEC;
    else if (bus.excepttype_i == XLEN'(32'h0e)) w_target = bus.cp0_epc_i;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  // Next-state: accept in RUN, leave FLUSH on the last flush cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:   if (w_exc) w_next = S_FLUSH;
      S_FLUSH: if (r_fcnt == FC_W'(1)) w_next = S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  // FSM outputs; the first FLUSH cycle is the one with a full counter.
  always_comb begin
    w_flush = 1'b0;
    w_busy  = 1'b0;
    w_pcv   = 1'b0;
    if (!rst && r_state == S_FLUSH) begin
      w_flush = 1'b1;
      w_busy  = 1'b1;
      w_pcv   = (r_fcnt == FC_W'(FLUSH_CYCLES));
    end
  end

  // Flush length counter and redirect target capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt   <= '0;
      r_new_pc <= '0;
    end else if (w_accept) begin
      r_fcnt   <= FC_W'(FLUSH_CYCLES);
      r_new_pc <= w_target;
    end else if (r_state == S_FLUSH && r_fcnt != '0) begin
      r_fcnt   <= r_fcnt - FC_W'(1);
    end
  end

  // Watchdog: consecutive stalled cycles, sticky timeout once the limit is hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (w_stall_any) begin
      if (r_wdog != WD_W'(WDOG_LIMIT)) r_wdog <= r_wdog + WD_W'(1);
      if (r_wdog == WD_W'(WDOG_LIMIT - 1)) r_timeout <= 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_stall_any && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_accept && r_redir_cnt != '1)    r_redir_cnt <= r_redir_cnt + CNT_W'(1);
    end
  end

  // Registered outputs are forced low while reset is held.
  assign bus.stall_o         = w_stall;
  assign bus.flush_o         = w_flush;
  assign bus.busy_o          = w_busy;
  assign bus.new_pc_valid_o  = w_pcv;
  assign bus.new_pc_o        = rst ? '0   : r_new_pc;
  assign bus.stall_timeout_o = rst ? 1'b0 : r_timeout;
  assign bus.stall_cycles_o  = rst ? '0   : r_stall_cnt;
  assign bus.redirect_cnt_o  = rst ? '0   : r_redir_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int ST = 6, XL = 32, FC = 2, WL = 8, CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGES(ST), .XLEN(XL), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .STAGES(ST), .XLEN(XL), .INT_VEC(32'h20), .EXC_VEC(32'h40),
    .FLUSH_CYCLES(FC), .WDOG_LIMIT(WL), .CNT_W(CW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0, n_fail = 0;

  // Model state.
  int              m_left;   // remaining flush cycles
  logic [XL-1:0]   m_pc;
  int              m_rc, m_sc, m_streak;
  bit              m_to;
  logic [ST-1:0]   m_req;
  logic [XL-1:0]   m_exc, m_epc;
  bit              m_rst;
  // Expectations for the current cycle.
  logic [ST-1:0]   e_stall;
  logic            e_flush, e_pcv, e_busy, e_to;
  logic [XL-1:0]   e_pc;
  logic [CW-1:0]   e_sc, e_rc;

  function automatic logic [XL-1:0] target(input logic [XL-1:0] c, input logic [XL-1:0] epc);
    if (c == 1)     return 32'h20;
    if (c == 32'he) return epc;
    return 32'h40;
  endfunction

  // Drive inputs for this cycle and compute what the outputs must be.
  task automatic tick(input logic [ST-1:0] req, input logic [XL-1:0] exc,
                      input logic [XL-1:0] epc, input bit r);
    int hi;
    bus.stall_req_i = req; bus.excepttype_i = exc; bus.cp0_epc_i = epc; rst = r;
    m_req = req; m_exc = exc; m_epc = epc; m_rst = r;
    #1;
    hi = -1;
    for (int k = 0; k < ST; k++) if (req[k]) hi = k;
    if (r || hi < 0 || exc != 0 || m_left > 0) e_stall = '0;
    else e_stall = ST'((1 << (hi + 1)) - 1);
    e_flush = !r && m_left > 0;
    e_busy  = e_flush;
    e_pcv   = !r && m_left == FC;
    e_pc    = r ? '0 : m_pc;
    e_to    = !r && m_to;
    e_sc    = r ? '0 : CW'(m_sc);
    e_rc    = r ? '0 : CW'(m_rc);
  endtask

  // Clock edge plus model update from the inputs of the cycle just ended.
  task automatic step();
    @(posedge clk);
    if (m_rst) begin
      m_left = 0; m_pc = '0; m_rc = 0; m_sc = 0; m_streak = 0; m_to = 0;
    end else begin
      if (e_stall != 0) begin
        if (m_sc < (1 << CW) - 1) m_sc++;
        m_streak++;
        if (m_streak >= WL) m_to = 1;
      end else m_streak = 0;
      if (m_left > 0) m_left--;
      else if (m_exc != 0) begin
        m_pc = target(m_exc, m_epc);
        m_left = FC;
        if (m_rc < (1 << CW) - 1) m_rc++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    tick('0, '0, '0, 1); step();
    tick('0, '0, '0, 1); step();
  endtask

  task automatic test_reset();
    logic [XL+3*CW+ST+3:0] obs;
    do_reset();
    tick('0, '0, '0, 0);
    obs = {bus.stall_o, bus.flush_o, bus.new_pc_valid_o, bus.new_pc_o, bus.busy_o,
           bus.stall_timeout_o, bus.stall_cycles_o, bus.redirect_cnt_o, CW'(0)};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
    step();
  endtask

  task automatic test_stall_map();
    logic [ST-1:0] req_t [4] = '{6'b001100, 6'b000100, 6'b000000, 6'b100001};
    logic [ST-1:0] exp_t [4] = '{6'b001111, 6'b000111, 6'b000000, 6'b111111};
    for (int i = 0; i < 4; i++) begin
      tick(req_t[i], '0, '0, 0);
      n_checks++;
      if (bus.stall_o !== exp_t[i]) begin
        n_fail++; $display("FAIL stall_map[%0d]: got %b want %b", i, bus.stall_o, exp_t[i]);
      end
      step();
    end
    // Stall request together with an exception: exception wins.
    tick(6'b000100, 32'h8, '0, 0);
    n_checks++;
    if (bus.stall_o !== '0) begin n_fail++; $display("FAIL stall_vs_exc: got %b want 0", bus.stall_o); end
    step();
    tick('0, '0, '0, 0); step();
    tick('0, '0, '0, 0); step();
  endtask

  task automatic test_redirect();
    logic [1:0] fl_t [3] = '{2'b11, 2'b10, 2'b00};  // {flush, pcv}
    int rc0;
    do_reset();
    rc0 = m_rc;
    tick('0, 32'h8, '0, 0); step();
    for (int i = 0; i < 3; i++) begin
      tick(6'b000010, '0, '0, 0);
      n_checks++;
      if ({bus.flush_o, bus.new_pc_valid_o} !== fl_t[i]) begin
        n_fail++; $display("FAIL redirect_flush[%0d]: got %b want %b", i, {bus.flush_o, bus.new_pc_valid_o}, fl_t[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (bus.new_pc_o !== 32'h40 || bus.redirect_cnt_o !== CW'(rc0 + 1)) begin
          n_fail++; $display("FAIL redirect_pc: got pc=%h cnt=%0d want pc=40 cnt=%0d", bus.new_pc_o, bus.redirect_cnt_o, rc0 + 1);
        end
      end
      step();
    end
  endtask

  task automatic test_eret_ignore();
    do_reset();
    tick('0, 32'he, 32'h1234, 0); step();
    tick('0, 32'h1, 32'h9999, 0);  // ignored: first FLUSH cycle
    n_checks++;
    if (bus.new_pc_o !== 32'h1234 || bus.new_pc_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL eret_pc: got %h v=%b want 1234 v=1", bus.new_pc_o, bus.new_pc_valid_o);
    end
    step();
    tick('0, 32'h1, 32'h9999, 0); step();  // ignored: second FLUSH cycle
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.redirect_cnt_o !== 4'd1 || bus.new_pc_o !== 32'h1234 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL eret_ignore: got cnt=%0d pc=%h busy=%b want 1 1234 0", bus.redirect_cnt_o, bus.new_pc_o, bus.busy_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] pat [6] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00};
    do_reset();
    tick('0, 32'h1, '0, 0); step();
    for (int i = 0; i < 6; i++) begin
      tick('0, 32'h1, '0, 0);
      n_checks++;
      if ({bus.flush_o, bus.new_pc_valid_o} !== pat[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: got %b want %b", i, {bus.flush_o, bus.new_pc_valid_o}, pat[i]);
      end
      step();
    end
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.redirect_cnt_o !== 4'd3 || bus.new_pc_o !== 32'h20) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d pc=%h want 3 pc=20", bus.redirect_cnt_o, bus.new_pc_o);
    end
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 7; i++) begin tick(6'b000100, '0, '0, 0); step(); end
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.stall_timeout_o !== 1'b0) begin n_fail++; $display("FAIL wdog_short: got 1 want 0"); end
    step();
    for (int i = 0; i < 7; i++) begin tick(6'b000100, '0, '0, 0); step(); end
    tick(6'b000100, '0, '0, 0);
    n_checks++;
    if (bus.stall_timeout_o !== 1'b0) begin n_fail++; $display("FAIL wdog_early: got 1 want 0 after 7"); end
    step();
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.stall_timeout_o !== 1'b1) begin n_fail++; $display("FAIL wdog_fire: got 0 want 1 after 8"); end
    step();
    tick('0, '0, '0, 0); step();
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.stall_timeout_o !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky: got 0 want 1"); end
    step();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    tick('0, 32'h8, '0, 0); step();
    tick('0, '0, '0, 0); step();
    tick(6'b000011, '0, '0, 1);  // reset during 2nd FLUSH cycle
    n_checks++;
    if ({bus.flush_o, bus.busy_o, bus.new_pc_o, bus.redirect_cnt_o, bus.stall_o} !== '0) begin
      n_fail++; $display("FAIL rst_mid_during: flush=%b busy=%b pc=%h", bus.flush_o, bus.busy_o, bus.new_pc_o);
    end
    step();
    tick('0, 32'hc, '0, 0);
    n_checks++;
    if ({bus.flush_o, bus.busy_o, bus.new_pc_valid_o, bus.new_pc_o, bus.redirect_cnt_o, bus.stall_timeout_o} !== '0) begin
      n_fail++; $display("FAIL rst_mid_after: flush=%b busy=%b pc=%h cnt=%0d", bus.flush_o, bus.busy_o, bus.new_pc_o, bus.redirect_cnt_o);
    end
    step();
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_accept: flush=%b v=%b want 1 1", bus.flush_o, bus.new_pc_valid_o);
    end
    step();
    tick('0, '0, '0, 0); step();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin tick(6'b010000, '0, '0, 0); step(); end
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.stall_cycles_o !== 4'hf) begin n_fail++; $display("FAIL stall_sat: got %h want f", bus.stall_cycles_o); end
    step();
    for (int i = 0; i < 20; i++) begin tick('0, 32'h8, '0, 0); step(); end
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.redirect_cnt_o !== 4'd7) begin n_fail++; $display("FAIL redir_cnt20: got %0d want 7", bus.redirect_cnt_o); end
    step();
    for (int i = 0; i < 40; i++) begin tick('0, 32'h8, '0, 0); step(); end
    tick('0, '0, '0, 0);
    n_checks++;
    if (bus.redirect_cnt_o !== 4'hf) begin n_fail++; $display("FAIL redir_sat: got %h want f", bus.redirect_cnt_o); end
    step();
  endtask

  task automatic test_random();
    logic [XL-1:0] codes [8] = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h55};
    logic [ST-1:0] req;
    logic [XL-1:0] exc;
    int errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) == 0) ? '0 : ST'($urandom);
      exc = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 7)] : '0;
      tick(req, exc, $urandom, $urandom_range(0, 99) == 0);
      n_checks++;
      if ({bus.stall_o, bus.flush_o, bus.new_pc_valid_o, bus.new_pc_o, bus.busy_o,
           bus.stall_timeout_o, bus.stall_cycles_o, bus.redirect_cnt_o} !==
          {e_stall, e_flush, e_pcv, e_pc, e_busy, e_to, e_sc, e_rc}) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random[%0d]: got st=%b f=%b v=%b pc=%h b=%b to=%b sc=%h rc=%h want st=%b f=%b v=%b pc=%h b=%b to=%b sc=%h rc=%h",
                   i, bus.stall_o, bus.flush_o, bus.new_pc_valid_o, bus.new_pc_o, bus.busy_o,
                   bus.stall_timeout_o, bus.stall_cycles_o, bus.redirect_cnt_o,
                   e_stall, e_flush, e_pcv, e_pc, e_busy, e_to, e_sc, e_rc);
      end
      step();
    end
  endtask

  initial begin
    m_left = 0; m_pc = '0; m_rc = 0; m_sc = 0; m_streak = 0; m_to = 0;
    test_reset();
    test_stall_map();
    test_redirect();
    test_eret_ignore();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
